// File: rtl/axis_slack_fifo.sv
// axis_slack_fifo
// AXI-Stream sink stage that absorbs the beats a source may still push after
// a late-arriving (registered) s_axis_tready falls. Beats are held in a
// DEPTH-entry show-ahead FIFO and re-presented as a standard AXI-Stream master.
// s_axis_tready is deasserted early enough to leave READY_LAT entries of slack.
//
// Optional feature: define AXIS_SLACK_FIFO_DROP_CNT_EN to add an 8-bit
// saturating drop_count output alongside the sticky overflow flag.
//
// Handshake semantics: on the master side a beat transfers on a rising edge
// where m_axis_tvalid && m_axis_tready; tvalid/tdata never change while a
// beat is offered and not taken. On the slave side acceptance is credit-style:
// any s_axis_tvalid beat is stored if there is room (or a slot frees on the
// same edge); s_axis_tready is only advisory and leads acceptance by READY_LAT.
module axis_slack_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int READY_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   occupancy,
`ifdef AXIS_SLACK_FIFO_DROP_CNT_EN
    output logic [7:0]            drop_count,
`endif
    output logic                  overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    // Highest post-edge count at which the source may still be invited to send.
    localparam logic [ADDR_WIDTH:0] READY_THR = (ADDR_WIDTH + 1)'(DEPTH - 1 - READY_LAT);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drop;

    // Flags, handshake qualifiers and next occupancy from the registered count.
    always_comb begin
        full       = (count == DEPTH_CNT);
        empty      = (count == '0);
        rd_en      = !empty && m_axis_tready;
        // A full FIFO still accepts a beat if the head leaves on the same edge.
        wr_en      = s_axis_tvalid && (!full || rd_en);
        drop       = s_axis_tvalid && full && !rd_en;
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array: written on accept, no reset needed (contents don't-care).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        end
    end

    // Pointers, count, registered ready and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_axis_tready <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= count_next;
            s_axis_tready <= (count_next <= READY_THR);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef AXIS_SLACK_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturating count of dropped beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_count = drop_cnt;
`endif

    // Show-ahead head of FIFO; valid straight from the registered count.
    assign m_axis_tdata  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign m_axis_tvalid = !empty;
    assign occupancy     = count;

endmodule

// File: tb/tb_axis_slack_fifo.sv
// Testbench for axis_slack_fifo: a driver issues beats one cycle at a time
// and runs a queue-based reference model of the FIFO rules; a monitor on the
// falling edge compares every DUT output against that model and pops the
// expected-data queue on each downstream handshake.
module tb_axis_slack_fifo;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int RL    = 1;
  localparam int DEPTH = 1 << AW;
  localparam int THR   = DEPTH - 1 - RL;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_axis_tdata  = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [AW:0]   occupancy;
  logic          overflow;
`ifdef AXIS_SLACK_FIFO_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  axis_slack_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READY_LAT (RL)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .occupancy    (occupancy),
`ifdef AXIS_SLACK_FIFO_DROP_CNT_EN
    .drop_count   (drop_count),
`endif
    .overflow     (overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];
  int m_count  = 0;
  bit m_ovf    = 1'b0;
  int m_drops  = 0;
  bit m_tready = 1'b0;
  int p_count;
  bit p_ovf;
  int p_drops;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: drives one cycle of inputs, predicts the
  // effect of the coming edge, then commits that prediction after the edge.
  task automatic step(input bit sv, input logic [DW-1:0] d, input bit mr);
    bit rd, wr;
    s_axis_tvalid = sv;
    s_axis_tdata  = d;
    m_axis_tready = mr;
    rd = (m_count > 0) && mr;
    wr = sv && ((m_count < DEPTH) || rd);
    if (wr) exp_q.push_back(d);
    p_count = m_count + int'(wr) - int'(rd);
    p_ovf   = m_ovf;
    p_drops = m_drops;
    if (sv && !wr) begin
      p_ovf = 1'b1;
      if (p_drops < 255) p_drops++;
    end
    @(posedge clk);
    #1;
    m_count  = p_count;
    m_ovf    = p_ovf;
    m_drops  = p_drops;
    m_tready = (m_count <= THR);
  endtask

  task automatic do_reset(input int cycles);
    rstn          = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    exp_q.delete();
    m_count  = 0;
    m_ovf    = 1'b0;
    m_drops  = 0;
    m_tready = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("tvalid", m_axis_tvalid, m_count > 0);
    check("occupancy", occupancy, m_count);
    check("s_tready", s_axis_tready, m_tready);
    check("overflow", overflow, m_ovf);
`ifdef AXIS_SLACK_FIFO_DROP_CNT_EN
    check("drop_count", drop_count, m_drops);
`endif
    if (m_axis_tvalid && (m_count > 0)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tdata: got 0x%0h, expected queue empty at %0t", m_axis_tdata, $time);
      end else begin
        check("tdata", m_axis_tdata, exp_q[0]);
        if (m_axis_tready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_occ", occupancy, 0);

    // single beat, visible one cycle after the write edge
    step(1'b1, 32'hA5A5A5A5, 1'b1);
    check("first_edge_tready", s_axis_tready, 1'b1);
    check("single_valid", m_axis_tvalid, 1'b1);
    check("single_data", m_axis_tdata, 32'hA5A5A5A5);
    step(1'b0, '0, 1'b1);
    check("single_occ", occupancy, 0);

    // slack fill: 17 beats into a stalled 16-deep FIFO
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 13) check("fill_tready_14", s_axis_tready, 1'b1);
      if (i == 14) check("fill_tready_15", s_axis_tready, 1'b0);
    end
    step(1'b0, '0, 1'b0);
    check("fill_occ", occupancy, 16);
    check("fill_ovf", overflow, 1'b1);
    check("fill_head", m_axis_tdata, 32'h0);
`ifdef AXIS_SLACK_FIFO_DROP_CNT_EN
    check("fill_drops", drop_count, 1);
`endif

    // drain: 0x00..0x0F in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      if (i == 1) check("drain_tready_14", s_axis_tready, 1'b1);
    end
    check("drain_occ", occupancy, 0);
    check("drain_ovf", overflow, 1'b1);

    // refill to full, then read and write on the same edge
    for (int i = 0; i < 16; i++) step(1'b1, DW'($urandom), 1'b0);
    step(1'b1, 32'h55, 1'b1);
    check("simul_occ", occupancy, 16);
`ifdef AXIS_SLACK_FIFO_DROP_CNT_EN
    check("simul_drops", drop_count, 1);
`endif
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1);
    check("simul_drained", occupancy, 0);

    // randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1);
    end

    // reset mid-stream with 9 beats buffered
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, DW'($urandom), 1'b0);
    check("pre_rst_occ", occupancy, 9);
    do_reset(2);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_valid", m_axis_tvalid, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    step(1'b0, '0, 1'b0);
    check("post_rst_tready", s_axis_tready, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
